nexus_work_scheduler: RTL and testbench
=======================================

Name: nexus_work_scheduler

Overview:
- Sequences a bank of SK1024 hash cores: takes a base nonce per work unit and loads each core with a disjoint nonce sub-range, one core per cycle.
- Times range exhaustion and pipeline drain, then requests new work.
- Round-robin arbitrates good-nonce results from all cores into one valid/ready result stream.
- Sits in the hash clock domain, between the work/CDC front end and the per-core transform instances.

Parameters:
CORES, 4, number of hash cores scheduled (1..16)
RANGE_LOG2, 32, log2 of nonces per core per work unit; also the RUN length in cycles (each core advances 1 nonce/cycle)
PIPE_DEPTH, 352, cycles to wait after RUN for in-flight hashes to retire (348 pipe stages + margin)

Ports:
clk  in  1  hash clock
nHashRst  in  1  asynchronous active-low reset
work_valid  in  1  new work unit offered
work_ready  out  1  scheduler accepts work this cycle
work_base_nonce  in  64  first nonce of work unit
abort  in  1  synchronous flush to IDLE
core_load  out  CORES  one-hot, one-cycle load strobe to core i
core_nonce  out  64  start nonce for the core being loaded
core_found  in  CORES  core i holds a good nonce (level until acked)
core_found_nonce  in  CORES*64  packed; core i at bits [64i+63:64i]
core_found_ack  out  CORES  one-hot, one-cycle ack; core drops found next cycle
res_valid  out  1  result available
res_ready  in  1  consumer takes result
res_nonce  out  64  good nonce
res_core  out  4  index of originating core
need_work  out  1  level: scheduler idle, work wanted
busy  out  1  state is LOAD, RUN or DRAIN

Behaviour:
- Reset (async assert): state IDLE; all outputs 0 except need_work=1 and work_ready=1; all counters and the RR pointer are 0.
- States: IDLE, LOAD, RUN, DRAIN.
- work_ready=1 in IDLE and RUN, 0 in LOAD and DRAIN. Accept = work_valid & work_ready; the base nonce is latched on accept.
- IDLE: on accept, go to LOAD with load index 0.
- LOAD: one core per cycle, i = 0..CORES-1.
  - core_load[i]=1 and core_nonce = base + i*2^RANGE_LOG2, mod 2^64 (wraps, no saturation).
  - After index CORES-1, go to RUN with counter = 2^RANGE_LOG2 - 1.
  - Latency from accept to first core_load is 1 cycle; load completes in CORES cycles.
- RUN: counter decrements each cycle; at 0, go to DRAIN with counter = PIPE_DEPTH-1. An accept in RUN preempts: go to LOAD immediately with the new base. Old in-flight results are still forwarded.
- DRAIN: counter decrements; at 0, go to IDLE and assert need_work.
- need_work = (state==IDLE).
- abort: from any state go to IDLE next cycle. Clears the load/run counters. Does not clear a pending result or the RR pointer. Higher priority than an accept in the same cycle.
- Result arbiter:
  - Output register is free when res_valid=0, or res_valid & res_ready in the same cycle.
  - When free and any core_found is set, grant the first set bit at or after rr_ptr, wrapping.
  - On grant: capture that core's nonce and index, assert res_valid next cycle, pulse core_found_ack[g] for one cycle, set rr_ptr = (g+1) mod CORES.
  - Throughput: 1 result/cycle under continuous res_ready.
  - res_nonce and res_core hold stable while res_valid & ~res_ready.
  - The arbiter runs in every state, including IDLE after abort.

Test Plan:
- CORES=4, RANGE_LOG2=4, PIPE_DEPTH=8; work_base_nonce=0x100 -> core_load 0001,0010,0100,1000 on 4 consecutive cycles starting 1 cycle after accept, core_nonce 0x100,0x110,0x120,0x130; RUN lasts 16 cycles, DRAIN 8; need_work rises exactly 1+4+16+8 cycles after accept.
- base=0xFFFF_FFFF_FFFF_FFF0, RANGE_LOG2=4 -> core_nonce sequence 0x...FFF0, 0x0, 0x10, 0x20 (wrap).
- core_found=1111 held with nonces 0xA0..0xA3, res_ready=1 -> res_core 0,1,2,3 on consecutive cycles, each core_found_ack a single-cycle one-hot pulse.
- core_found=0101 with res_ready=0 for 5 cycles -> res_valid=1 with res_core=0, stable; core 2 not acked until res_ready=1; then res_core=2 the next cycle.
- Accept new work (base 0x5000) mid-RUN -> LOAD restarts at core 0 with 0x5000; abort during LOAD -> IDLE next cycle, need_work=1, no further core_load.
- Assert nHashRst=0 mid-RUN with res_valid=1 -> all outputs 0 immediately (need_work and work_ready 1); after release, the first grant starts from core 0.

Source files
------------

// File: rtl/nexus_work_scheduler_if.sv
// Bundle of the work, core-control and result signals of the nexus work scheduler.
// The scheduler uses the slave view; the work front end / core bank uses master.
interface nexus_work_scheduler_if #(
    parameter int CORES = 4
);
    logic                  work_valid;
    logic                  work_ready;
    logic [63:0]           work_base_nonce;
    logic                  abort;
    logic [CORES-1:0]      core_load;
    logic [63:0]           core_nonce;
    logic [CORES-1:0]      core_found;
    logic [CORES*64-1:0]   core_found_nonce;
    logic [CORES-1:0]      core_found_ack;
    logic                  res_valid;
    logic                  res_ready;
    logic [63:0]           res_nonce;
    logic [3:0]            res_core;
    logic                  need_work;
    logic                  busy;

    modport master (
        output work_valid, work_base_nonce, abort, core_found, core_found_nonce, res_ready,
        input  work_ready, core_load, core_nonce, core_found_ack, res_valid, res_nonce,
               res_core, need_work, busy
    );

    modport slave (
        input  work_valid, work_base_nonce, abort, core_found, core_found_nonce, res_ready,
        output work_ready, core_load, core_nonce, core_found_ack, res_valid, res_nonce,
               res_core, need_work, busy
    );
endinterface

// File: rtl/nexus_work_scheduler.sv
// Nexus work scheduler: loads each hash core with a disjoint nonce sub-range,
// times range exhaustion and pipeline drain, and round-robin arbitrates the
// good nonces reported by the cores into a single valid/ready result stream.
module nexus_work_scheduler #(
    parameter int CORES      = 4,
    parameter int RANGE_LOG2 = 32,
    parameter int PIPE_DEPTH = 352
) (
    input  logic                  clk,
    input  logic                  nHashRst,
    nexus_work_scheduler_if.slave bus
);
    localparam int IW = (CORES > 1) ? $clog2(CORES) : 1;
    localparam int PW = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
    localparam int CW = (RANGE_LOG2 > PW) ? RANGE_LOG2 : PW;

    localparam logic [CW-1:0] RUN_INIT   = CW'({RANGE_LOG2{1'b1}});
    localparam logic [CW-1:0] DRAIN_INIT = CW'(PIPE_DEPTH - 1);
    localparam logic [IW-1:0] LAST_IDX   = IW'(CORES - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [63:0]      base_q, base_d;
    logic             work_ready_q;
    logic             need_work_q;
    logic             busy_q;
    logic [CORES-1:0] core_load_q;
    logic [63:0]      core_nonce_q;
    logic             accept;

    assign accept = bus.work_valid & work_ready_q;

    // Next-state decode; abort outranks everything, an accept in RUN preempts the range
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        if (bus.abort) begin
            state_d = S_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        state_d = S_LOAD;
                        idx_d   = '0;
                        base_d  = bus.work_base_nonce;
                    end
                end
                S_LOAD: begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_RUN;
                        idx_d   = '0;
                        cnt_d   = RUN_INIT;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        state_d = S_LOAD;
                        idx_d   = '0;
                        base_d  = bus.work_base_nonce;
                    end else if (cnt_q == '0) begin
                        state_d = S_DRAIN;
                        cnt_d   = DRAIN_INIT;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: begin
                    if (cnt_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            endcase
        end
    end

    // Sequencer state plus outputs registered from the next state so they line up with it
    always_ff @(posedge clk or negedge nHashRst) begin
        if (!nHashRst) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            base_q       <= '0;
            work_ready_q <= 1'b1;
            need_work_q  <= 1'b1;
            busy_q       <= 1'b0;
            core_load_q  <= '0;
            core_nonce_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            base_q       <= base_d;
            work_ready_q <= (state_d == S_IDLE) || (state_d == S_RUN);
            need_work_q  <= (state_d == S_IDLE);
            busy_q       <= (state_d != S_IDLE);
            core_load_q  <= (state_d == S_LOAD) ? (CORES'(1) << idx_d) : '0;
            core_nonce_q <= (state_d == S_LOAD) ? (base_d + (64'(idx_d) << RANGE_LOG2)) : '0;
        end
    end

    // ---------------- result arbiter ----------------
    logic [63:0]      found_nonce [CORES];
    logic [CORES-1:0] found_eff;
    logic [CORES-1:0] ack_q;
    logic [IW-1:0]    rr_q;
    logic             res_valid_q;
    logic [63:0]      res_nonce_q;
    logic [3:0]       res_core_q;
    logic             grant_valid;
    logic [IW-1:0]    grant_idx;
    logic [IW-1:0]    cand_idx;
    int               cand;
    logic             res_free;

    generate
        for (genvar gi = 0; gi < CORES; gi++) begin : g_unpack
            assign found_nonce[gi] = bus.core_found_nonce[64*gi +: 64];
        end
    endgenerate

    // A core being acked this cycle still shows found; it must not be granted twice
    assign found_eff = bus.core_found & ~ack_q;
    assign res_free  = ~res_valid_q | bus.res_ready;

    // Round-robin pick: lowest offset from rr_q wins, so scan offsets from high to low
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int k = CORES - 1; k >= 0; k--) begin
            cand = int'(rr_q) + k;
            if (cand >= CORES) begin
                cand = cand - CORES;
            end
            cand_idx = IW'(cand);
            if (found_eff[cand_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // Result register, ack pulse and pointer update; runs in every sequencer state
    always_ff @(posedge clk or negedge nHashRst) begin
        if (!nHashRst) begin
            res_valid_q <= 1'b0;
            res_nonce_q <= '0;
            res_core_q  <= '0;
            ack_q       <= '0;
            rr_q        <= '0;
        end else begin
            ack_q <= '0;
            if (res_free) begin
                res_valid_q <= grant_valid;
                if (grant_valid) begin
                    res_nonce_q <= found_nonce[grant_idx];
                    res_core_q  <= 4'(grant_idx);
                    ack_q       <= CORES'(1) << grant_idx;
                    rr_q        <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
                end
            end
        end
    end

    assign bus.work_ready     = work_ready_q;
    assign bus.need_work      = need_work_q;
    assign bus.busy           = busy_q;
    assign bus.core_load      = core_load_q;
    assign bus.core_nonce     = core_nonce_q;
    assign bus.core_found_ack = ack_q;
    assign bus.res_valid      = res_valid_q;
    assign bus.res_nonce      = res_nonce_q;
    assign bus.res_core       = res_core_q;
endmodule

// File: tb/tb_nexus_work_scheduler.sv
// Self-checking bench for nexus_work_scheduler (CORES=4, RANGE_LOG2=4, PIPE_DEPTH=8).
module tb_nexus_work_scheduler;
    logic clk;
    logic nHashRst;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    nexus_work_scheduler_if #(.CORES(4)) bus ();

    nexus_work_scheduler #(
        .CORES      (4),
        .RANGE_LOG2 (4),
        .PIPE_DEPTH (8)
    ) dut (
        .clk      (clk),
        .nHashRst (nHashRst),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wv;
        logic [63:0] base;
        logic        ab;
        logic [3:0]  e_load;
        logic [63:0] e_nonce;
        logic        e_need;
        logic        e_wr;
        logic        e_busy;
    } vec_t;

    vec_t vecs [11];

    function automatic vec_t mk(input logic wv, input logic [63:0] base, input logic ab,
                                input logic [3:0] el, input logic [63:0] en,
                                input logic need, input logic wr, input logic bsy);
        vec_t v;
        v.wv = wv; v.base = base; v.ab = ab;
        v.e_load = el; v.e_nonce = en; v.e_need = need; v.e_wr = wr; v.e_busy = bsy;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: cores drop found on the edge after they saw their ack pulse
    task automatic step();
        logic [3:0] ack_before;
        ack_before = bus.core_found_ack;
        @(posedge clk);
        #1;
        bus.core_found = bus.core_found & ~ack_before;
    endtask

    task automatic apply_row(input int r);
        bus.work_valid      = vecs[r].wv;
        bus.work_base_nonce = vecs[r].base;
        bus.abort           = vecs[r].ab;
        step();
        check($sformatf("row%0d_core_load", r),  64'(bus.core_load), 64'(vecs[r].e_load));
        check($sformatf("row%0d_core_nonce", r), bus.core_nonce,     vecs[r].e_nonce);
        check($sformatf("row%0d_need_work", r),  64'(bus.need_work), 64'(vecs[r].e_need));
        check($sformatf("row%0d_work_ready", r), 64'(bus.work_ready), 64'(vecs[r].e_wr));
        check($sformatf("row%0d_busy", r),       64'(bus.busy),      64'(vecs[r].e_busy));
        $display("vec %0d: load=%b nonce=0x%0h need=%0b wr=%0b busy=%0b",
                 r, bus.core_load, bus.core_nonce, bus.need_work, bus.work_ready, bus.busy);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_nw;
        int wr19;
        int wr21;
        int stray;

        vecs[0]  = mk(1'b1, 64'h100, 1'b0, 4'b0001, 64'h100, 1'b0, 1'b0, 1'b1);
        vecs[1]  = mk(1'b0, 64'h0,   1'b0, 4'b0010, 64'h110, 1'b0, 1'b0, 1'b1);
        vecs[2]  = mk(1'b0, 64'h0,   1'b0, 4'b0100, 64'h120, 1'b0, 1'b0, 1'b1);
        vecs[3]  = mk(1'b0, 64'h0,   1'b0, 4'b1000, 64'h130, 1'b0, 1'b0, 1'b1);
        vecs[4]  = mk(1'b0, 64'h0,   1'b0, 4'b0000, 64'h0,   1'b0, 1'b1, 1'b1);
        vecs[5]  = mk(1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 4'b0001, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 1'b0, 1'b1);
        vecs[6]  = mk(1'b0, 64'h0,   1'b0, 4'b0010, 64'h0,   1'b0, 1'b0, 1'b1);
        vecs[7]  = mk(1'b0, 64'h0,   1'b0, 4'b0100, 64'h10,  1'b0, 1'b0, 1'b1);
        vecs[8]  = mk(1'b0, 64'h0,   1'b0, 4'b1000, 64'h20,  1'b0, 1'b0, 1'b1);
        vecs[9]  = mk(1'b0, 64'h0,   1'b0, 4'b0000, 64'h0,   1'b0, 1'b1, 1'b1);
        vecs[10] = mk(1'b0, 64'h0,   1'b1, 4'b0000, 64'h0,   1'b1, 1'b1, 1'b0);

        nHashRst             = 1'b0;
        bus.work_valid       = 1'b0;
        bus.work_base_nonce  = '0;
        bus.abort            = 1'b0;
        bus.core_found       = '0;
        bus.core_found_nonce = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
        bus.res_ready        = 1'b0;

        // Reset state
        #12;
        check("rst_need_work",  64'(bus.need_work),  64'd1);
        check("rst_work_ready", 64'(bus.work_ready), 64'd1);
        check("rst_busy",       64'(bus.busy),       64'd0);
        check("rst_core_load",  64'(bus.core_load),  64'd0);
        check("rst_res_valid",  64'(bus.res_valid),  64'd0);
        $display("reset: need=%0b wr=%0b busy=%0b", bus.need_work, bus.work_ready, bus.busy);
        nHashRst = 1'b1;

        // Load sequence from base 0x100, then time RUN/DRAIN to need_work
        for (int r = 0; r <= 4; r++) apply_row(r);
        bus.work_valid = 1'b0;
        first_nw = -1;
        wr19 = -1;
        wr21 = -1;
        for (int n = 5; n <= 40 && first_nw < 0; n++) begin
            step();
            if (n == 19) wr19 = int'(bus.work_ready);
            if (n == 21) wr21 = int'(bus.work_ready);
            if (bus.need_work && first_nw < 0) first_nw = n;
        end
        check("need_work_latency", 64'(first_nw), 64'd28);
        check("work_ready_run_end", 64'(wr19), 64'd1);
        check("work_ready_drain", 64'(wr21), 64'd0);
        $display("timing: need_work after %0d edges past accept edge", first_nw);

        // Wrapping base, then abort out of RUN
        for (int r = 5; r <= 10; r++) apply_row(r);
        bus.work_valid = 1'b0;
        bus.abort      = 1'b0;

        // Abort beats accept in the same cycle
        bus.work_valid      = 1'b1;
        bus.work_base_nonce = 64'h777;
        bus.abort           = 1'b1;
        step();
        check("abort_vs_accept_load", 64'(bus.core_load), 64'd0);
        check("abort_vs_accept_busy", 64'(bus.busy), 64'd0);
        $display("abort+accept: load=%b busy=%0b", bus.core_load, bus.busy);
        bus.work_valid = 1'b0;
        bus.abort      = 1'b0;
        step();

        // Preempt mid-RUN with base 0x5000, then abort during LOAD
        bus.work_valid      = 1'b1;
        bus.work_base_nonce = 64'h200;
        step();
        bus.work_valid = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check("run_before_preempt_wr", 64'(bus.work_ready), 64'd1);
        bus.work_valid      = 1'b1;
        bus.work_base_nonce = 64'h5000;
        step();
        bus.work_valid = 1'b0;
        check("preempt_load0", 64'(bus.core_load), 64'b0001);
        check("preempt_nonce0", bus.core_nonce, 64'h5000);
        check("preempt_wr", 64'(bus.work_ready), 64'd0);
        $display("preempt: load=%b nonce=0x%0h", bus.core_load, bus.core_nonce);
        step();
        check("preempt_load1", 64'(bus.core_load), 64'b0010);
        check("preempt_nonce1", bus.core_nonce, 64'h5010);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check("abort_load_core_load", 64'(bus.core_load), 64'd0);
        check("abort_load_need_work", 64'(bus.need_work), 64'd1);
        check("abort_load_busy", 64'(bus.busy), 64'd0);
        $display("abort in LOAD: load=%b need=%0b", bus.core_load, bus.need_work);
        stray = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus.core_load != 4'b0000) stray++;
        end
        check("abort_no_more_loads", 64'(stray), 64'd0);

        // All four cores found, consumer always ready
        bus.res_ready  = 1'b1;
        bus.core_found = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("rr%0d_valid", k), 64'(bus.res_valid), 64'd1);
            check($sformatf("rr%0d_core", k), 64'(bus.res_core), 64'(k));
            check($sformatf("rr%0d_nonce", k), bus.res_nonce, 64'hA0 + 64'(k));
            check($sformatf("rr%0d_ack", k), 64'(bus.core_found_ack), 64'd1 << k);
            $display("grant: core=%0d nonce=0x%0h ack=%b", bus.res_core, bus.res_nonce, bus.core_found_ack);
        end
        step();
        check("rr_done_valid", 64'(bus.res_valid), 64'd0);
        check("rr_done_ack", 64'(bus.core_found_ack), 64'd0);

        // Back-pressure: cores 0 and 2 found, consumer stalled
        bus.res_ready  = 1'b0;
        bus.core_found = 4'b0101;
        step();
        check("bp_first_core", 64'(bus.res_core), 64'd0);
        check("bp_first_ack", 64'(bus.core_found_ack), 64'b0001);
        for (int i = 1; i < 5; i++) begin
            step();
            check($sformatf("bp%0d_valid", i), 64'(bus.res_valid), 64'd1);
            check($sformatf("bp%0d_core", i), 64'(bus.res_core), 64'd0);
            check($sformatf("bp%0d_nonce", i), bus.res_nonce, 64'hA0);
            check($sformatf("bp%0d_ack2", i), 64'(bus.core_found_ack[2]), 64'd0);
        end
        $display("stall: valid=%0b core=%0d nonce=0x%0h", bus.res_valid, bus.res_core, bus.res_nonce);
        bus.res_ready = 1'b1;
        step();
        check("bp_release_core", 64'(bus.res_core), 64'd2);
        check("bp_release_nonce", bus.res_nonce, 64'hA2);
        check("bp_release_ack", 64'(bus.core_found_ack), 64'b0100);
        $display("release: core=%0d ack=%b", bus.res_core, bus.core_found_ack);
        step();
        check("bp_after_valid", 64'(bus.res_valid), 64'd0);

        // Async reset mid-RUN with a pending result; pointer must restart at core 0
        bus.res_ready       = 1'b0;
        bus.work_valid      = 1'b1;
        bus.work_base_nonce = 64'h300;
        step();
        bus.work_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        bus.core_found = 4'b0010;
        step();
        check("pre_rst_core", 64'(bus.res_core), 64'd1);
        step();
        bus.core_found = bus.core_found | 4'b1001;
        #2;
        nHashRst = 1'b0;
        #1;
        check("arst_res_valid", 64'(bus.res_valid), 64'd0);
        check("arst_res_nonce", bus.res_nonce, 64'd0);
        check("arst_res_core", 64'(bus.res_core), 64'd0);
        check("arst_ack", 64'(bus.core_found_ack), 64'd0);
        check("arst_core_load", 64'(bus.core_load), 64'd0);
        check("arst_core_nonce", bus.core_nonce, 64'd0);
        check("arst_need_work", 64'(bus.need_work), 64'd1);
        check("arst_work_ready", 64'(bus.work_ready), 64'd1);
        check("arst_busy", 64'(bus.busy), 64'd0);
        $display("async reset: valid=%0b need=%0b busy=%0b", bus.res_valid, bus.need_work, bus.busy);
        #1;
        nHashRst      = 1'b1;
        bus.res_ready = 1'b1;
        step();
        check("post_rst_grant_valid", 64'(bus.res_valid), 64'd1);
        check("post_rst_grant_core", 64'(bus.res_core), 64'd0);
        $display("post reset grant: core=%0d", bus.res_core);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
